md5_fghi: RTL and testbench

Single-block MD5 compression core. It accepts one pre-padded 512-bit block as sixteen 32-bit little-endian words. It runs the 64 MD5 steps (the F, G, H and I rounds) at one step per clock and adds the standard initial vector. It presents the 128-bit digest as four 32-bit words with a valid flag. It sits behind a padding and formatting stage that supplies complete blocks; multi-block chaining is out of scope.

---
 rtl/md5_fghi.sv | 207 ++++++++++++++++++++
 tb/tb_md5_fghi.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/md5_fghi.sv
// Single-block MD5 compression core: latches a padded 512-bit block, runs the 64 steps
// at one per clock, then adds the initial vector and presents the digest with a valid flag.
module md5_fghi (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic [31:0] M_0,
  input  logic [31:0] M_1,
  input  logic [31:0] M_2,
  input  logic [31:0] M_3,
  input  logic [31:0] M_4,
  input  logic [31:0] M_5,
  input  logic [31:0] M_6,
  input  logic [31:0] M_7,
  input  logic [31:0] M_8,
  input  logic [31:0] M_9,
  input  logic [31:0] M_10,
  input  logic [31:0] M_11,
  input  logic [31:0] M_12,
  input  logic [31:0] M_13,
  input  logic [31:0] M_14,
  input  logic [31:0] M_15,
  output logic        valid,
  output logic [31:0] Oword_0,
  output logic [31:0] Oword_1,
  output logic [31:0] Oword_2,
  output logic [31:0] Oword_3
);

  localparam logic [31:0] IvA = 32'h67452301;
  localparam logic [31:0] IvB = 32'hEFCDAB89;
  localparam logic [31:0] IvC = 32'h98BADCFE;
  localparam logic [31:0] IvD = 32'h10325476;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  // Bit 6 set marks the extra edge after step 63 that writes the digest.
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [31:0] m_q [16];
  logic [31:0] m_d [16];
  logic [31:0] m_in [16];
  logic [31:0] oword_q [4];
  logic [31:0] oword_d [4];
  logic        valid_q, valid_d;

  logic [31:0] f;
  logic [3:0]  g;
  logic [31:0] sum;
  logic [31:0] new_b;

  assign m_in = '{M_0, M_1, M_2, M_3, M_4, M_5, M_6, M_7,
                  M_8, M_9, M_10, M_11, M_12, M_13, M_14, M_15};

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    unique case (idx)
      6'd0:  k_rom = 32'hd76aa478;  6'd1:  k_rom = 32'he8c7b756;
      6'd2:  k_rom = 32'h242070db;  6'd3:  k_rom = 32'hc1bdceee;
      6'd4:  k_rom = 32'hf57c0faf;  6'd5:  k_rom = 32'h4787c62a;
      6'd6:  k_rom = 32'ha8304613;  6'd7:  k_rom = 32'hfd469501;
      6'd8:  k_rom = 32'h698098d8;  6'd9:  k_rom = 32'h8b44f7af;
      6'd10: k_rom = 32'hffff5bb1;  6'd11: k_rom = 32'h895cd7be;
      6'd12: k_rom = 32'h6b901122;  6'd13: k_rom = 32'hfd987193;
      6'd14: k_rom = 32'ha679438e;  6'd15: k_rom = 32'h49b40821;
      6'd16: k_rom = 32'hf61e2562;  6'd17: k_rom = 32'hc040b340;
      6'd18: k_rom = 32'h265e5a51;  6'd19: k_rom = 32'he9b6c7aa;
      6'd20: k_rom = 32'hd62f105d;  6'd21: k_rom = 32'h02441453;
      6'd22: k_rom = 32'hd8a1e681;  6'd23: k_rom = 32'he7d3fbc8;
      6'd24: k_rom = 32'h21e1cde6;  6'd25: k_rom = 32'hc33707d6;
      6'd26: k_rom = 32'hf4d50d87;  6'd27: k_rom = 32'h455a14ed;
      6'd28: k_rom = 32'ha9e3e905;  6'd29: k_rom = 32'hfcefa3f8;
      6'd30: k_rom = 32'h676f02d9;  6'd31: k_rom = 32'h8d2a4c8a;
      6'd32: k_rom = 32'hfffa3942;  6'd33: k_rom = 32'h8771f681;
      6'd34: k_rom = 32'h6d9d6122;  6'd35: k_rom = 32'hfde5380c;
      6'd36: k_rom = 32'ha4beea44;  6'd37: k_rom = 32'h4bdecfa9;
      6'd38: k_rom = 32'hf6bb4b60;  6'd39: k_rom = 32'hbebfbc70;
      6'd40: k_rom = 32'h289b7ec6;  6'd41: k_rom = 32'heaa127fa;
      6'd42: k_rom = 32'hd4ef3085;  6'd43: k_rom = 32'h04881d05;
      6'd44: k_rom = 32'hd9d4d039;  6'd45: k_rom = 32'he6db99e5;
      6'd46: k_rom = 32'h1fa27cf8;  6'd47: k_rom = 32'hc4ac5665;
      6'd48: k_rom = 32'hf4292244;  6'd49: k_rom = 32'h432aff97;
      6'd50: k_rom = 32'hab9423a7;  6'd51: k_rom = 32'hfc93a039;
      6'd52: k_rom = 32'h655b59c3;  6'd53: k_rom = 32'h8f0ccc92;
      6'd54: k_rom = 32'hffeff47d;  6'd55: k_rom = 32'h85845dd1;
      6'd56: k_rom = 32'h6fa87e4f;  6'd57: k_rom = 32'hfe2ce6e0;
      6'd58: k_rom = 32'ha3014314;  6'd59: k_rom = 32'h4e0811a1;
      6'd60: k_rom = 32'hf7537e82;  6'd61: k_rom = 32'hbd3af235;
      6'd62: k_rom = 32'h2ad7d2bb;  default: k_rom = 32'heb86d391;
    endcase
  endfunction

  function automatic logic [4:0] s_rom(input logic [1:0] rnd, input logic [1:0] col);
    unique case ({rnd, col})
      4'h0: s_rom = 5'd7;   4'h1: s_rom = 5'd12;  4'h2: s_rom = 5'd17;  4'h3: s_rom = 5'd22;
      4'h4: s_rom = 5'd5;   4'h5: s_rom = 5'd9;   4'h6: s_rom = 5'd14;  4'h7: s_rom = 5'd20;
      4'h8: s_rom = 5'd4;   4'h9: s_rom = 5'd11;  4'hA: s_rom = 5'd16;  4'hB: s_rom = 5'd23;
      4'hC: s_rom = 5'd6;   4'hD: s_rom = 5'd10;  4'hE: s_rom = 5'd15;  default: s_rom = 5'd21;
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] sh);
    logic [63:0] dbl;
    dbl  = {x, x} << sh;
    rotl = dbl[63:32];
  endfunction

  // Round function and message index; the mod-16 multiplies only need the low 4 bits of i.
  always_comb begin
    f = 32'h0;
    g = 4'h0;
    unique case (cnt_q[5:4])
      2'd0: begin
        f = (b_q & c_q) | (~b_q & d_q);
        g = cnt_q[3:0];
      end
      2'd1: begin
        f = (d_q & b_q) | (~d_q & c_q);
        g = 4'(cnt_q[3:0] * 4'd5 + 4'd1);
      end
      2'd2: begin
        f = b_q ^ c_q ^ d_q;
        g = 4'(cnt_q[3:0] * 4'd3 + 4'd5);
      end
      default: begin
        f = c_q ^ (b_q | ~d_q);
        g = 4'(cnt_q[3:0] * 4'd7);
      end
    endcase
    sum   = a_q + f + k_rom(cnt_q[5:0]) + m_q[g];
    new_b = b_q + rotl(sum, s_rom(cnt_q[5:4], cnt_q[1:0]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    m_d     = m_q;
    valid_d = valid_q;
    oword_d = oword_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          m_d     = m_in;
          a_d     = IvA;
          b_d     = IvB;
          c_d     = IvC;
          d_d     = IvD;
          cnt_d   = 7'd0;
          valid_d = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q[6]) begin
          oword_d = '{a_q + IvA, b_q + IvB, c_q + IvC, d_q + IvD};
          valid_d = 1'b1;
          state_d = StDone;
        end else begin
          a_d   = d_q;
          d_d   = c_q;
          c_d   = b_q;
          b_d   = new_b;
          cnt_d = cnt_q + 7'd1;
        end
      end
      StDone: begin
        if (!go) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 7'd0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      c_q     <= 32'h0;
      d_q     <= 32'h0;
      m_q     <= '{default: 32'h0};
      valid_q <= 1'b0;
      oword_q <= '{default: 32'h0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      m_q     <= m_d;
      valid_q <= valid_d;
      oword_q <= oword_d;
    end
  end

  assign valid   = valid_q;
  assign Oword_0 = oword_q[0];
  assign Oword_1 = oword_q[1];
  assign Oword_2 = oword_q[2];
  assign Oword_3 = oword_q[3];

endmodule

// File: tb/tb_md5_fghi.sv
// Directed bench for md5_fghi: table of single-block messages with known MD5 digests,
// plus sequences for input changes mid-run, go retrigger, and reset mid-run.
module tb_md5_fghi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic [31:0] m [16];
  logic        valid;
  logic [31:0] ow0, ow1, ow2, ow3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  md5_fghi dut (
    .clk(clk), .reset_n(reset_n), .go(go),
    .M_0(m[0]), .M_1(m[1]), .M_2(m[2]), .M_3(m[3]),
    .M_4(m[4]), .M_5(m[5]), .M_6(m[6]), .M_7(m[7]),
    .M_8(m[8]), .M_9(m[9]), .M_10(m[10]), .M_11(m[11]),
    .M_12(m[12]), .M_13(m[13]), .M_14(m[14]), .M_15(m[15]),
    .valid(valid), .Oword_0(ow0), .Oword_1(ow1), .Oword_2(ow2), .Oword_3(ow3)
  );

  typedef struct {
    string       name;
    logic [31:0] m0;
    logic [31:0] m14;
    logic [31:0] e0, e1, e2, e3;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_digest(input string name, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    check({name, " Oword_0"}, ow0, e0);
    check({name, " Oword_1"}, ow1, e1);
    check({name, " Oword_2"}, ow2, e2);
    check({name, " Oword_3"}, ow3, e3);
  endtask

  // Drives the block and go before an edge; that edge is the start edge.
  task automatic start(input string name, input logic [31:0] m0, input logic [31:0] m14);
    @(negedge clk);
    foreach (m[k]) m[k] = 32'h0;
    m[0]  = m0;
    m[14] = m14;
    go    = 1'b1;
    @(posedge clk);
    #1;
    check({name, " valid cleared on start"}, {31'h0, valid}, 32'h0);
  endtask

  // Counts edges after the start edge until valid; optional M_0 change after edge chg_edge-1.
  task automatic wait_done(input string name, input int chg_edge, input logic [31:0] chg_val);
    int n;
    n = 0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (e == chg_edge - 1) m[0] = chg_val;
      if (valid) begin
        n = e;
        break;
      end
    end
    check({name, " latency"}, n, 65);
  endtask

  task automatic finish_go();
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // "1" -> md5 c4ca4238a0b923820dcc509a6f75849b, little-endian words below.
    vecs[0] = '{"one", 32'h00008031, 32'd8,
                32'h3842CAC4, 32'h8223B9A0, 32'h9A50CC0D, 32'h9B84756F};
    vecs[1] = '{"empty", 32'h00000080, 32'd0,
                32'hD98C1DD4, 32'h04B2008F, 32'h980980E9, 32'h7E42F8EC};
    vecs[2] = '{"abc", 32'h80636261, 32'd24,
                32'h98500190, 32'hB04FD23C, 32'h7D3F96D6, 32'h727FE128};

    reset_n = 1'b0;
    go      = 1'b0;
    foreach (m[k]) m[k] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", {31'h0, valid}, 32'h0);
    check_digest("reset", 32'h0, 32'h0, 32'h0, 32'h0);

    for (int v = 0; v < 3; v++) begin
      start(vecs[v].name, vecs[v].m0, vecs[v].m14);
      wait_done(vecs[v].name, 0, 32'h0);
      check_digest(vecs[v].name, vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3);
      repeat (3) @(posedge clk);
      #1;
      check({vecs[v].name, " valid held with go"}, {31'h0, valid}, 32'h1);
      check_digest({vecs[v].name, " held"}, vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3);
      finish_go();
      repeat (2) @(posedge clk);
      #1;
      check({vecs[v].name, " valid kept in idle"}, {31'h0, valid}, 32'h1);
    end

    // Input change mid-run is ignored; then retrigger with the new block.
    start("latch", 32'h80636261, 32'd24);
    wait_done("latch", 10, 32'h00008031);
    check_digest("latch abc", 32'h98500190, 32'hB04FD23C, 32'h7D3F96D6, 32'h727FE128);
    finish_go();
    @(negedge clk);
    m[14] = 32'd8;
    go    = 1'b1;
    @(posedge clk);
    #1;
    check("retrigger valid cleared", {31'h0, valid}, 32'h0);
    check_digest("retrigger old kept", 32'h98500190, 32'hB04FD23C, 32'h7D3F96D6, 32'h727FE128);
    wait_done("retrigger", 0, 32'h0);
    check_digest("retrigger one", 32'h3842CAC4, 32'h8223B9A0, 32'h9A50CC0D, 32'h9B84756F);
    finish_go();

    // Reset asserted for edge 30 of a run aborts it and clears outputs.
    start("abort", 32'h80636261, 32'd24);
    repeat (28) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort valid", {31'h0, valid}, 32'h0);
    check_digest("abort", 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    go      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort stays idle", {31'h0, valid}, 32'h0);
    start("after abort", 32'h00000080, 32'd0);
    wait_done("after abort", 0, 32'h0);
    check_digest("after abort", 32'hD98C1DD4, 32'h04B2008F, 32'h980980E9, 32'h7E42F8EC);
    finish_go();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
